nios2_oci_monitor_ctrl: RTL

//  Debug-monitor memory engine in the clk domain, directly downstream of the JTAG debug-module sysclk stage.

---
 rtl/oci_mon_pkg.sv | 18 +
 rtl/nios2_oci_mon_timer.sv | 30 +++
 rtl/nios2_oci_monitor_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/oci_mon_pkg.sv
// Shared constants for the debug-monitor memory engine: FSM state encodings,
// jdo field positions and the data word reported when an access is aborted.
package oci_mon_pkg;

  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_IDLE    = 2'd0;
  localparam mon_state_t ST_RD_REQ  = 2'd1;
  localparam mon_state_t ST_RD_WAIT = 2'd2;
  localparam mon_state_t ST_WR_REQ  = 2'd3;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_DATA_LSB  = 3;
  localparam int JDO_RDREQ_BIT = 34;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/nios2_oci_mon_timer.sv
// Access watchdog for the monitor engine: cleared by load, advanced by count,
// and expire pulses on the TIMEOUT_CYC-th consecutive counted cycle.
module nios2_oci_mon_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter, restarted whenever the engine is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = count && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/nios2_oci_monitor_ctrl.sv
// Debug-monitor memory engine: turns JTAG ocimem strobes into word accesses on
// the debug-RAM master port and reports MonDReg / ready / error back.
// Optional feature macro: OCI_MON_TIMEOUT_EN (abort stalled accesses after
// TIMEOUT_CYC cycles). Without it the engine waits on a stalled slave forever.
module nios2_oci_monitor_ctrl
  import oci_mon_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid
);

  mon_state_t        state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              post_inc;
  logic              any_strobe;
  logic              abort;
  logic              unused_jdo;

  assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign mem_address = mon_a_reg;
  assign unused_jdo  = ^{jdo[37:35], jdo[2:0]};

`ifdef OCI_MON_TIMEOUT_EN
  logic busy;

  assign busy = (state != ST_IDLE);

  nios2_oci_mon_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (!busy),
    .count   (busy),
    .expire  (abort)
  );
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  // Engine FSM, address/data registers, bus requests and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mon_a_reg     <= '0;
      post_inc      <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
    end else begin
      // Ready lags the state by one cycle so it drops only after acceptance.
      monitor_ready <= (state == ST_IDLE);

      case (state)
        ST_IDLE: begin
          // Priority: address load > write > streamed read.
          if (take_action_ocimem_a) begin
            mon_a_reg     <= jdo[JDO_ADDR_LSB +: ADDR_W];
            monitor_error <= 1'b0;
            if (jdo[JDO_RDREQ_BIT]) begin
              state    <= ST_RD_REQ;
              mem_read <= 1'b1;
              post_inc <= 1'b0;
            end
          end else if (take_action_ocimem_b) begin
            mem_writedata <= jdo[JDO_DATA_LSB +: 32];
            MonDReg       <= jdo[JDO_DATA_LSB +: 32];
            state         <= ST_WR_REQ;
            mem_write     <= 1'b1;
          end else if (take_no_action_ocimem_a) begin
            state    <= ST_RD_REQ;
            mem_read <= 1'b1;
            post_inc <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_readdatavalid) begin
            MonDReg <= mem_readdata;
            state   <= ST_IDLE;
            if (post_inc) begin
              mon_a_reg <= mon_a_reg + 1'b1;
            end
          end
        end
        default: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            mon_a_reg <= mon_a_reg + 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase

      // Strobes arriving while busy are dropped and latch a sticky error.
      if ((state != ST_IDLE) && any_strobe) begin
        monitor_error <= 1'b1;
      end

      // Watchdog abort overrides whatever the access was doing.
      if (abort) begin
        state         <= ST_IDLE;
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        MonDReg       <= TIMEOUT_DATA;
        monitor_error <= 1'b1;
      end
    end
  end

endmodule
